fpu_mem_dma: RTL and testbench

Memory transfer engine directly downstream of the FPU controller. It services the controller's `request_read` and `request_write` pulses by moving one chunk between main memory and the FPU row buffers. A chunk is `COL_WIDTH` rows of `MEM_BUFFER_WIDTH` bytes, with rows separated by a byte stride in memory. The engine drives `making_request` back to the controller while any transfer is in flight.

---
 rtl/fpu_mem_dma.sv | 273 +++++++++++++++++++++++++++
 tb/tb_fpu_mem_dma.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mem_dma.sv
// Chunk transfer engine between main memory and the FPU row buffers.
// One read slot and one write slot; reads win when both are waiting.
module fpu_mem_dma #(
  parameter int unsigned COL_WIDTH        = 10,
  parameter int unsigned MEM_BUFFER_WIDTH = 512,
  parameter int unsigned WORDS            = MEM_BUFFER_WIDTH / 4,
  parameter int unsigned RW               = $clog2(COL_WIDTH),
  parameter int unsigned WW               = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          request_read,
  input  logic [31:0]   read_address,
  input  logic          request_write,
  input  logic [31:0]   write_address,
  input  logic [17:0]   row_stride,
  output logic          making_request,
  output logic          overflow,
  output logic          mem_req,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          rdbuf_we,
  output logic [RW-1:0] rdbuf_row,
  output logic [WW-1:0] rdbuf_word,
  output logic [31:0]   rdbuf_wdata,
  output logic          wrbuf_re,
  output logic [RW-1:0] wrbuf_row,
  output logic [WW-1:0] wrbuf_word,
  input  logic [31:0]   wrbuf_rdata
);

  typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrFetch, StWrReq} state_e;

  localparam logic [RW-1:0] LastRow  = RW'(COL_WIDTH - 1);
  localparam logic [WW-1:0] LastWord = WW'(WORDS - 1);

  state_e        state_q, state_d;
  logic          rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
  logic [31:0]   rd_base_q, rd_base_d, wr_base_q, wr_base_d;
  logic [17:0]   rd_stride_q, rd_stride_d, wr_stride_q, wr_stride_d;
  logic [RW-1:0] r_q, r_d;
  logic [WW-1:0] w_q, w_d;
  logic [31:0]   row_base_q, row_base_d, stride_q, stride_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d, wdata_q, wdata_d;
  logic          wr_first_q, wr_first_d;
  logic          wrbuf_re_q, wrbuf_re_d;
  logic [RW-1:0] wrbuf_row_q, wrbuf_row_d;
  logic [WW-1:0] wrbuf_word_q, wrbuf_word_d;
  logic          overflow_q, overflow_d, making_request_q, making_request_d;

  logic          last_word, last_pos, rd_act, wr_act, rd_done, wr_done;
  logic          rd_ovf, wr_ovf, rd_take, wr_take, eff_rd_pend, eff_wr_pend;
  logic [31:0]   eff_rd_base, eff_wr_base;
  logic [17:0]   eff_rd_stride, eff_wr_stride;
  logic [RW-1:0] nxt_r;
  logic [WW-1:0] nxt_w;
  logic [31:0]   nxt_base, nxt_addr;
  logic          start_rd, start_wr;

  assign last_word = (w_q == LastWord);
  assign last_pos  = last_word && (r_q == LastRow);
  assign nxt_w     = last_word ? '0 : w_q + WW'(1);
  assign nxt_r     = last_word ? r_q + RW'(1) : r_q;
  assign nxt_base  = last_word ? row_base_q + stride_q : row_base_q;
  assign nxt_addr  = nxt_base + (32'(nxt_w) << 2);

  assign rd_act  = (state_q == StRdReq) || (state_q == StRdWait);
  assign wr_act  = (state_q == StWrFetch) || (state_q == StWrReq);
  assign rd_done = (state_q == StRdWait) && mem_rvalid && last_pos;
  assign wr_done = (state_q == StWrReq) && mem_ack && last_pos;

  // A same-type request landing in the transfer's final cycle is accepted, not dropped.
  assign rd_ovf  = request_read && (rd_pend_q || (rd_act && !rd_done));
  assign wr_ovf  = request_write && (wr_pend_q || (wr_act && !wr_done));
  assign rd_take = request_read && !rd_ovf;
  assign wr_take = request_write && !wr_ovf;

  assign eff_rd_pend   = rd_pend_q || rd_take;
  assign eff_wr_pend   = wr_pend_q || wr_take;
  assign eff_rd_base   = rd_take ? read_address : rd_base_q;
  assign eff_wr_base   = wr_take ? write_address : wr_base_q;
  assign eff_rd_stride = rd_take ? row_stride : rd_stride_q;
  assign eff_wr_stride = wr_take ? row_stride : wr_stride_q;

  always_comb begin
    state_d      = state_q;
    rd_pend_d    = rd_pend_q;
    wr_pend_d    = wr_pend_q;
    rd_base_d    = rd_base_q;
    wr_base_d    = wr_base_q;
    rd_stride_d  = rd_stride_q;
    wr_stride_d  = wr_stride_q;
    r_d          = r_q;
    w_d          = w_q;
    row_base_d   = row_base_q;
    stride_d     = stride_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    wdata_d      = wdata_q;
    wr_first_d   = 1'b0;
    wrbuf_re_d   = 1'b0;
    wrbuf_row_d  = wrbuf_row_q;
    wrbuf_word_d = wrbuf_word_q;
    overflow_d   = overflow_q | rd_ovf | wr_ovf;
    start_rd     = 1'b0;
    start_wr     = 1'b0;

    if (rd_take) begin
      rd_pend_d   = 1'b1;
      rd_base_d   = read_address;
      rd_stride_d = row_stride;
    end
    if (wr_take) begin
      wr_pend_d   = 1'b1;
      wr_base_d   = write_address;
      wr_stride_d = row_stride;
    end

    unique case (state_q)
      StIdle: begin
        if (eff_rd_pend)      start_rd = 1'b1;
        else if (eff_wr_pend) start_wr = 1'b1;
      end
      StRdReq: begin
        if (mem_ack) begin
          state_d   = StRdWait;
          mem_req_d = 1'b0;
        end
      end
      StRdWait: begin
        if (mem_rvalid) begin
          if (last_pos) begin
            if (eff_wr_pend) start_wr = 1'b1;
            else             state_d  = StIdle;
          end else begin
            r_d        = nxt_r;
            w_d        = nxt_w;
            row_base_d = nxt_base;
            mem_addr_d = nxt_addr;
            mem_req_d  = 1'b1;
            state_d    = StRdReq;
          end
        end
      end
      StWrFetch: begin
        state_d    = StWrReq;
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b1;
        wr_first_d = 1'b1;
      end
      StWrReq: begin
        if (wr_first_q) wdata_d = wrbuf_rdata;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (last_pos) begin
            if (eff_rd_pend) start_rd = 1'b1;
            else             state_d  = StIdle;
          end else begin
            r_d          = nxt_r;
            w_d          = nxt_w;
            row_base_d   = nxt_base;
            mem_addr_d   = nxt_addr;
            wrbuf_re_d   = 1'b1;
            wrbuf_row_d  = nxt_r;
            wrbuf_word_d = nxt_w;
            state_d      = StWrFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_rd) begin
      state_d    = StRdReq;
      rd_pend_d  = 1'b0;
      r_d        = '0;
      w_d        = '0;
      row_base_d = eff_rd_base;
      stride_d   = {14'd0, eff_rd_stride};
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = eff_rd_base;
    end
    if (start_wr) begin
      state_d      = StWrFetch;
      wr_pend_d    = 1'b0;
      r_d          = '0;
      w_d          = '0;
      row_base_d   = eff_wr_base;
      stride_d     = {14'd0, eff_wr_stride};
      mem_req_d    = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = eff_wr_base;
      wrbuf_re_d   = 1'b1;
      wrbuf_row_d  = '0;
      wrbuf_word_d = '0;
    end

    making_request_d = (state_d != StIdle) || rd_pend_d || wr_pend_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      rd_pend_q        <= 1'b0;
      wr_pend_q        <= 1'b0;
      rd_base_q        <= '0;
      wr_base_q        <= '0;
      rd_stride_q      <= '0;
      wr_stride_q      <= '0;
      r_q              <= '0;
      w_q              <= '0;
      row_base_q       <= '0;
      stride_q         <= '0;
      mem_req_q        <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= '0;
      wdata_q          <= '0;
      wr_first_q       <= 1'b0;
      wrbuf_re_q       <= 1'b0;
      wrbuf_row_q      <= '0;
      wrbuf_word_q     <= '0;
      overflow_q       <= 1'b0;
      making_request_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      rd_pend_q        <= rd_pend_d;
      wr_pend_q        <= wr_pend_d;
      rd_base_q        <= rd_base_d;
      wr_base_q        <= wr_base_d;
      rd_stride_q      <= rd_stride_d;
      wr_stride_q      <= wr_stride_d;
      r_q              <= r_d;
      w_q              <= w_d;
      row_base_q       <= row_base_d;
      stride_q         <= stride_d;
      mem_req_q        <= mem_req_d;
      mem_we_q         <= mem_we_d;
      mem_addr_q       <= mem_addr_d;
      wdata_q          <= wdata_d;
      wr_first_q       <= wr_first_d;
      wrbuf_re_q       <= wrbuf_re_d;
      wrbuf_row_q      <= wrbuf_row_d;
      wrbuf_word_q     <= wrbuf_word_d;
      overflow_q       <= overflow_d;
      making_request_q <= making_request_d;
    end
  end

  assign making_request = making_request_q;
  assign overflow       = overflow_q;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  // Sync write buffer delivers data in the first request cycle; hold it from then on.
  assign mem_wdata      = wr_first_q ? wrbuf_rdata : wdata_q;
  assign wrbuf_re       = wrbuf_re_q;
  assign wrbuf_row      = wrbuf_row_q;
  assign wrbuf_word     = wrbuf_word_q;

  assign rdbuf_we    = (state_q == StRdWait) && mem_rvalid;
  assign rdbuf_row   = rdbuf_we ? r_q : '0;
  assign rdbuf_word  = rdbuf_we ? w_q : '0;
  assign rdbuf_wdata = rdbuf_we ? mem_rdata : '0;

endmodule

// File: tb/tb_fpu_mem_dma.sv
// Bench for fpu_mem_dma: vector table (fixed + random) against a chunk-level address/data
// model, plus hand sequences for overflow, final-cycle request and reset mid-transfer.
module tb_fpu_mem_dma;
  localparam int unsigned ColW   = 2;
  localparam int unsigned MbW    = 16;
  localparam int unsigned Words  = MbW / 4;
  localparam int unsigned Rw     = $clog2(ColW);
  localparam int unsigned Ww     = $clog2(Words);
  localparam int unsigned NWords = ColW * Words;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          request_read = 1'b0, request_write = 1'b0;
  logic [31:0]   read_address = '0, write_address = '0;
  logic [17:0]   row_stride = '0;
  logic          making_request, overflow, mem_req, mem_we;
  logic [31:0]   mem_addr, mem_wdata;
  logic          mem_ack = 1'b0, mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          rdbuf_we, wrbuf_re;
  logic [Rw-1:0] rdbuf_row, wrbuf_row;
  logic [Ww-1:0] rdbuf_word, wrbuf_word;
  logic [31:0]   rdbuf_wdata;
  logic [31:0]   wrbuf_rdata = '0;

  fpu_mem_dma #(.COL_WIDTH(ColW), .MEM_BUFFER_WIDTH(MbW)) dut (
    .clk(clk), .rst_n(rst_n),
    .request_read(request_read), .read_address(read_address),
    .request_write(request_write), .write_address(write_address),
    .row_stride(row_stride), .making_request(making_request), .overflow(overflow),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rdbuf_we(rdbuf_we), .rdbuf_row(rdbuf_row), .rdbuf_word(rdbuf_word),
    .rdbuf_wdata(rdbuf_wdata), .wrbuf_re(wrbuf_re), .wrbuf_row(wrbuf_row),
    .wrbuf_word(wrbuf_word), .wrbuf_rdata(wrbuf_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Word k of a chunk lives at base + row*stride + 4*word, 32-bit wrap.
  function automatic logic [31:0] exp_addr(input logic [31:0] base, input logic [17:0] stride,
                                           input int k);
    logic [31:0] r = 32'(k / Words);
    logic [31:0] w = 32'(k % Words);
    return base + r * {14'd0, stride} + 4 * w;
  endfunction

  // Memory / write-buffer responder and activity logger
  int          cyc = 0;
  bit          resp_en = 1'b1;
  int          ack_delay = 0;
  bit          rnd_ack = 1'b0;
  int          stall_cnt = 0, cur_delay = 0;
  bit          rd_out = 1'b0;
  logic [31:0] rd_out_addr = '0;
  bit          re_pend = 1'b0;
  int          re_idx = 0;
  logic [31:0] wb_mem [NWords];
  logic [31:0] tx_addr[$], tx_wdata[$], rb_data[$];
  logic        tx_we[$];
  int          rb_idx[$];
  int          mk_cnt, mk_rises, wre_cnt, last_rd_cyc, first_wre_cyc, stab_err;
  bit          prev_mk = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  logic        prev_we = 1'b0;

  task automatic clear_logs();
    tx_addr.delete(); tx_wdata.delete(); tx_we.delete(); rb_idx.delete(); rb_data.delete();
    mk_cnt = 0; mk_rises = 0; wre_cnt = 0; stab_err = 0;
    last_rd_cyc = -1; first_wre_cyc = -1;
  endtask

  initial begin
    clear_logs();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mem_ack = 1'b0; mem_rvalid = 1'b0; rd_out = 1'b0; re_pend = 1'b0;
        stall_cnt = 0; prev_stall = 1'b0;
      end else if (resp_en) begin
        if (re_pend) wrbuf_rdata = wb_mem[re_idx];
        mem_rvalid = rd_out;
        mem_rdata  = rd_out ? rd_out_addr : 32'h0;
        rd_out = 1'b0;
        if (mem_req) begin
          if (stall_cnt == 0) cur_delay = rnd_ack ? int'($urandom_range(0, 3)) : ack_delay;
          if (stall_cnt >= cur_delay) begin mem_ack = 1'b1; stall_cnt = 0; end
          else begin mem_ack = 1'b0; stall_cnt++; end
        end else begin
          mem_ack = 1'b0; stall_cnt = 0;
        end
      end
      #1;
      if (rst_n) begin
        re_pend = wrbuf_re;
        re_idx  = int'(wrbuf_row) * Words + int'(wrbuf_word);
        if (mem_req && mem_ack) begin
          tx_addr.push_back(mem_addr); tx_we.push_back(mem_we); tx_wdata.push_back(mem_wdata);
          if (!mem_we) begin rd_out = 1'b1; rd_out_addr = mem_addr; end
        end
        if (rdbuf_we) begin
          rb_idx.push_back(int'(rdbuf_row) * Words + int'(rdbuf_word));
          rb_data.push_back(rdbuf_wdata);
          last_rd_cyc = cyc;
        end
        if (wrbuf_re) begin
          wre_cnt++;
          if (first_wre_cyc < 0) first_wre_cyc = cyc;
        end
        if (making_request) mk_cnt++;
        if (making_request && !prev_mk) mk_rises++;
        prev_mk = making_request;
        if (prev_stall && mem_req &&
            (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata))
          stab_err++;
        prev_stall = mem_req && !mem_ack;
        prev_addr = mem_addr; prev_we = mem_we; prev_wdata = mem_wdata;
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (making_request && n < 3000) begin
      @(negedge clk); #2;
      n++;
    end
    check(name, 32'(n < 3000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    bit          do_rd;
    bit          do_wr;
    logic [31:0] rd_base;
    logic [31:0] wr_base;
    logic [17:0] stride;
    int          delay;
    bit          rnd;
    int          exp_mk;
  } vec_t;

  task automatic run_vec(input vec_t v, input int id);
    int nrd = v.do_rd ? NWords : 0;
    int nwr = v.do_wr ? NWords : 0;
    ack_delay = v.delay;
    rnd_ack   = v.rnd;
    for (int k = 0; k < NWords; k++)
      wb_mem[k] = v.rnd ? $urandom : 32'((k / Words) * 16 + k % Words);
    @(negedge clk);
    clear_logs();
    request_read = v.do_rd; read_address = v.rd_base;
    request_write = v.do_wr; write_address = v.wr_base; row_stride = v.stride;
    @(negedge clk);
    request_read = 1'b0; request_write = 1'b0;
    check($sformatf("v%0d_lat_mk", id), 32'(making_request), 32'd1);
    check($sformatf("v%0d_lat_start", id), 32'(mem_req | wrbuf_re), 32'd1);
    wait_idle($sformatf("v%0d_timeout", id));
    check($sformatf("v%0d_ntx", id), 32'(tx_addr.size()), 32'(nrd + nwr));
    for (int k = 0; k < tx_addr.size() && k < nrd + nwr; k++) begin
      if (k < nrd) begin
        check($sformatf("v%0d_raddr%0d", id, k), tx_addr[k], exp_addr(v.rd_base, v.stride, k));
        check($sformatf("v%0d_rwe%0d", id, k), 32'(tx_we[k]), 32'd0);
      end else begin
        check($sformatf("v%0d_waddr%0d", id, k - nrd), tx_addr[k],
              exp_addr(v.wr_base, v.stride, k - nrd));
        check($sformatf("v%0d_wwe%0d", id, k - nrd), 32'(tx_we[k]), 32'd1);
        check($sformatf("v%0d_wdata%0d", id, k - nrd), tx_wdata[k], wb_mem[k - nrd]);
      end
    end
    check($sformatf("v%0d_nrb", id), 32'(rb_idx.size()), 32'(nrd));
    for (int k = 0; k < rb_idx.size() && k < nrd; k++) begin
      check($sformatf("v%0d_rbpos%0d", id, k), 32'(rb_idx[k]), 32'(k));
      check($sformatf("v%0d_rbdata%0d", id, k), rb_data[k], exp_addr(v.rd_base, v.stride, k));
    end
    check($sformatf("v%0d_nwre", id), 32'(wre_cnt), 32'(nwr));
    check($sformatf("v%0d_mk_rises", id), 32'(mk_rises), 32'd1);
    check($sformatf("v%0d_stable", id), 32'(stab_err), 32'd0);
    if (v.exp_mk != 0) check($sformatf("v%0d_mk_cycles", id), 32'(mk_cnt), 32'(v.exp_mk));
    if (v.do_rd && v.do_wr)
      check($sformatf("v%0d_rd_first", id), 32'(first_wre_cyc > last_rd_cyc), 32'd1);
  endtask

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    vecs[0] = '{1, 0, 32'h1000_0200, 32'h0, 18'h40, 0, 0, 16};
    vecs[1] = '{0, 1, 32'h0, 32'h2000_0000, 18'h40, 0, 0, 16};
    vecs[2] = '{1, 1, 32'h3000_0000, 32'h4000_0100, 18'h40, 0, 0, 32};
    vecs[3] = '{1, 0, 32'h1000_0000, 32'h0, 18'h40, 3, 0, 40};
    vecs[4] = '{0, 1, 32'h0, 32'h2000_1000, 18'h40, 3, 0, 40};
    vecs[5] = '{1, 0, 32'hFFFF_FFF8, 32'h0, 18'h40, 0, 0, 16};
    for (int i = 6; i < 12; i++) begin
      int kind = int'($urandom_range(0, 2));
      vecs[i] = '{kind != 1, kind != 0, $urandom, $urandom, 18'($urandom), 0, 1, 0};
    end

    #12;
    check("rst_mk", 32'(making_request), 32'd0);
    check("rst_req", 32'(mem_req | mem_we | wrbuf_re | rdbuf_we | overflow), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Write request in the final read cycle: making_request must never drop
    ack_delay = 0; rnd_ack = 1'b0; found = 1'b0;
    @(negedge clk);
    clear_logs();
    request_read = 1'b1; read_address = 32'h7000_0000; row_stride = 18'h40;
    @(negedge clk); request_read = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk); #2;
      if (rdbuf_we && rdbuf_row == 1'b1 && rdbuf_word == 2'd3) begin
        request_write = 1'b1; write_address = 32'h7100_0000; found = 1'b1;
      end
    end
    @(negedge clk); request_write = 1'b0;
    check("fin_found", 32'(found), 32'd1);
    wait_idle("fin_timeout");
    check("fin_mk_rises", 32'(mk_rises), 32'd1);
    check("fin_mk_cycles", 32'(mk_cnt), 32'd32);
    check("fin_ntx", 32'(tx_addr.size()), 32'd16);
    check("fin_nwre", 32'(wre_cnt), 32'd8);

    // Overflow: second read during an active read is dropped
    @(negedge clk);
    clear_logs();
    request_read = 1'b1; read_address = 32'h5000_0000;
    @(negedge clk); request_read = 1'b0;
    repeat (3) @(negedge clk);
    check("ovf_before", 32'(overflow), 32'd0);
    request_read = 1'b1; read_address = 32'h6000_0000;
    @(negedge clk); request_read = 1'b0;
    check("ovf_set", 32'(overflow), 32'd1);
    wait_idle("ovf_timeout");
    check("ovf_ntx", 32'(tx_addr.size()), 32'd8);
    if (tx_addr.size() == 8) begin
      check("ovf_first", tx_addr[0], 32'h5000_0000);
      check("ovf_last", tx_addr[7], exp_addr(32'h5000_0000, 18'h40, 7));
    end
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset during word 3 of a read, then a stray rvalid
    @(negedge clk);
    clear_logs();
    request_read = 1'b1; read_address = 32'h0800_0000;
    @(negedge clk); request_read = 1'b0;
    for (int n = 0; n < 100 && rb_idx.size() < 2; n++) @(negedge clk);
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_mk", 32'(making_request), 32'd0);
    check("mid_rst_ctl", 32'(mem_req | mem_we | wrbuf_re | rdbuf_we | overflow), 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    check("mid_rst_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    resp_en = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hABCD_0123;
    #1;
    check("stray_rvalid", 32'(rdbuf_we), 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    check("stray_idle", 32'(making_request | mem_req), 32'd0);
    resp_en = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
